// File: rtl/tx_pkg.sv
// Shared types and constants for the packet transmitter: FSM states, SYNC pattern,
// bit-stuffing limit and the {dplus, dminus} line encodings.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        SYNC,
        DATA,
        EOP_SE0A,
        EOP_SE0B,
        EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;
    localparam int         RUN_W       = 3;

    // Line symbols packed as {dplus, dminus}
    typedef logic [1:0] line_t;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    function automatic line_t nrzi_toggle(input line_t l);
        return (l == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/tx_nrzi_stuff.sv
// NRZI encoder with bit stuffing: a 0 toggles J/K, a 1 holds; once STUFF_LIMIT ones
// have gone out, the next strobe sends a stuffed 0 and stall tells the caller to hold its bit.
module tx_nrzi_stuff
    import tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic bit_in,
    input  logic bit_strobe,
    input  logic run_rst,
    output logic dplus,
    output logic dminus,
    output logic stall
);

    logic [RUN_W-1:0] ones_q, ones_d;
    line_t            line_q, line_d;

    assign stall           = (ones_q == RUN_W'(STUFF_LIMIT));
    assign {dplus, dminus} = line_q;

    // run_rst also re-arms the level at J, matching the idle line ahead of SYNC
    always_comb begin
        ones_d = ones_q;
        line_d = line_q;
        if (run_rst) begin
            ones_d = '0;
            line_d = LINE_J;
        end else if (bit_strobe) begin
            if (stall || !bit_in) begin
                ones_d = '0;
                line_d = nrzi_toggle(line_q);
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q <= '0;
            line_q <= LINE_J;
        end else begin
            ones_q <= ones_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/tx_ctrl.sv
// Packet transmit controller: inter-packet gap, SYNC, byte-wise payload with
// underflow abort, then SE0-SE0-J end of packet. Line state follows the bit strobe.
module tx_ctrl
    import tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       bit_strobe,
    output logic       enable_timer_bits51,
    input  logic       bits51,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    tx_state_e  state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       last_q, last_d;
    logic       need_q, need_d;
    logic       eop_pend_q, eop_pend_d;
    logic       tx_done_q, tx_done_d;
    logic       tx_error_q, tx_error_d;
    logic       tx_busy_q, tx_busy_d;
    logic       timer_en_q, timer_en_d;

    logic       enc_stb, enc_bit, run_rst, stall;
    logic       enc_dp, enc_dm;
    logic [7:0] cur_byte;
    logic       cur_last;
    line_t      line;

    // A byte may be accepted on the very strobe that starts it, so bit 0 comes straight from tx_data
    assign tx_ready = (state_q == DATA) && need_q && tx_valid;
    assign cur_byte = need_q ? tx_data : shreg_q;
    assign cur_last = need_q ? tx_last : last_q;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        need_d     = need_q;
        eop_pend_d = eop_pend_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        enc_stb    = 1'b0;
        enc_bit    = 1'b0;
        run_rst    = 1'b0;
        if (tx_ready) begin
            shreg_d = tx_data;
            last_d  = tx_last;
            need_d  = 1'b0;
        end
        unique case (state_q)
            IDLE: if (tx_start) state_d = GAP;
            GAP: begin
                if (bits51) begin
                    state_d   = SYNC;
                    bit_idx_d = '0;
                    run_rst   = 1'b1;
                end
            end
            SYNC: begin
                enc_bit = SYNC_BYTE[bit_idx_q];
                if (bit_strobe) begin
                    enc_stb = 1'b1;
                    if (!stall) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_d    = DATA;
                            need_d     = 1'b1;
                            eop_pend_d = 1'b0;
                        end
                    end
                end
            end
            DATA: begin
                enc_bit = cur_byte[0];
                if (bit_strobe) begin
                    // A pending stuff bit always goes out first, even after the final data bit
                    if (stall) begin
                        enc_stb = 1'b1;
                    end else if (eop_pend_q) begin
                        state_d = EOP_SE0A;
                    end else if (need_q && !tx_valid) begin
                        state_d    = EOP_SE0A;
                        tx_error_d = 1'b1;
                    end else begin
                        enc_stb   = 1'b1;
                        shreg_d   = {1'b0, cur_byte[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            if (cur_last) eop_pend_d = 1'b1;
                            else          need_d     = 1'b1;
                        end
                    end
                end
            end
            EOP_SE0A: if (bit_strobe) state_d = EOP_SE0B;
            EOP_SE0B: if (bit_strobe) state_d = EOP_J;
            EOP_J: begin
                if (bit_strobe) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_busy_d  = (state_d != IDLE);
        timer_en_d = (state_d == GAP);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            need_q     <= 1'b0;
            eop_pend_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            timer_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            need_q     <= need_d;
            eop_pend_q <= eop_pend_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
            tx_busy_q  <= tx_busy_d;
            timer_en_q <= timer_en_d;
        end
    end

    tx_nrzi_stuff u_nrzi (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_in     (enc_bit),
        .bit_strobe (enc_stb),
        .run_rst    (run_rst),
        .dplus      (enc_dp),
        .dminus     (enc_dm),
        .stall      (stall)
    );

    // Every select term is a flop that only moves on a strobe, so the line does too
    always_comb begin
        unique case (state_q)
            SYNC, DATA:         line = {enc_dp, enc_dm};
            EOP_SE0A, EOP_SE0B: line = LINE_SE0;
            default:            line = LINE_J;
        endcase
    end

    assign {dplus_out, dminus_out} = line;
    assign enable_timer_bits51     = timer_en_q;
    assign tx_busy                 = tx_busy_q;
    assign tx_done                 = tx_done_q;
    assign tx_error                = tx_error_q;

endmodule
